// File: rtl/dtpu_infifo.sv
// Input word FIFO between the PS-side AXI-Stream DMA and dtpu_core.
// First-word-fall-through head, registered pointers with a wrap bit, sticky protocol-error flags.
module dtpu_infifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] infifo_dout,
    output logic                  infifo_last,
    output logic                  infifo_is_empty,
    input  logic                  infifo_read,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  underflow,
    output logic                  overflow
);

    localparam logic [ADDR_WIDTH:0] STALL_MAX = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH:0] mem [DEPTH];
    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic [ADDR_WIDTH:0] stall_cnt;
    logic                empty;
    logic                full;
    logic                wr_en;
    logic                rd_en;
    logic                stall;

    // Handshake: a word transfers on any edge where s_axis_tvalid && s_axis_tready;
    // tready depends only on registered pointers, never on tvalid or infifo_read.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                   (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
    assign wr_en = s_axis_tvalid && !full;
    assign rd_en = infifo_read && !empty;
    assign stall = s_axis_tvalid && full;

    assign s_axis_tready   = !full;
    assign infifo_is_empty = empty;
    assign level           = wr_ptr - rd_ptr;
    assign {infifo_last, infifo_dout} = mem[rd_ptr[ADDR_WIDTH-1:0]];

    // Storage is deliberately not reset; the head is only meaningful when not empty.
    always_ff @(posedge clk) begin
        if (!reset && !flush && wr_en) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tdata};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            stall_cnt <= '0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            stall_cnt <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            if (infifo_read && empty) underflow <= 1'b1;
            if (!stall) begin
                stall_cnt <= '0;
            end else if (stall_cnt != STALL_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            // The edge that brings the counter to DEPTH is the one that raises the flag.
            if (stall && (stall_cnt >= STALL_MAX - 1'b1)) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dtpu_infifo.sv
// Directed bench for dtpu_infifo: a table of single-cycle vectors plus
// hand-written multi-cycle sequences for fill/stall, streaming wrap and overflow.
module tb_dtpu_infifo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [63:0] s_axis_tdata = '0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [63:0] infifo_dout;
    logic        infifo_last;
    logic        infifo_is_empty;
    logic        infifo_read = 1'b0;
    logic [4:0]  level;
    logic        underflow;
    logic        overflow;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dtpu_infifo #(.DATA_WIDTH(64), .DEPTH(16), .ADDR_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .infifo_dout(infifo_dout), .infifo_last(infifo_last),
        .infifo_is_empty(infifo_is_empty), .infifo_read(infifo_read),
        .level(level), .underflow(underflow), .overflow(overflow)
    );

    typedef struct {
        logic        flush;
        logic        tvalid;
        logic        tlast;
        logic        rd;
        logic [63:0] tdata;
        logic        e_empty;
        logic [4:0]  e_level;
        logic        e_tready;
        logic        chk_dout;
        logic [63:0] e_dout;
        logic        e_last;
        logic        e_uf;
        logic        e_of;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic fl, logic tv, logic tl, logic rd, logic [63:0] td,
                                logic ee, logic [4:0] el, logic et, logic cd,
                                logic [63:0] ed, logic elast, logic euf, logic eof);
        vec_t v;
        v.flush = fl; v.tvalid = tv; v.tlast = tl; v.rd = rd; v.tdata = td;
        v.e_empty = ee; v.e_level = el; v.e_tready = et; v.chk_dout = cd;
        v.e_dout = ed; v.e_last = elast; v.e_uf = euf; v.e_of = eof;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fl, input logic tv, input logic tl,
                         input logic rd, input logic [63:0] td);
        flush = fl; s_axis_tvalid = tv; s_axis_tlast = tl; infifo_read = rd; s_axis_tdata = td;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        // Single-cycle vectors: first word, pop, underflow, partial fill, flush.
        vecs.push_back(mk(0,1,0,0,64'hCAFECAFECAFECAFE, 0,5'd1,1, 1,64'hCAFECAFECAFECAFE,0, 0,0));
        vecs.push_back(mk(0,0,0,1,64'h0,                1,5'd0,1, 0,64'h0,0,              0,0));
        vecs.push_back(mk(0,0,0,1,64'h0,                1,5'd0,1, 0,64'h0,0,              1,0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0,1,(i == 4),0,64'h100 + 64'(i), 0,5'(i + 1),1, 1,64'h100,0, 1,0));
        vecs.push_back(mk(1,1,0,1,64'h999,              1,5'd0,1, 0,64'h0,0,              1,0));
        vecs.push_back(mk(0,0,0,0,64'h0,                1,5'd0,1, 0,64'h0,0,              1,0));
        vecs.push_back(mk(0,1,1,0,64'hABC,              0,5'd1,1, 1,64'hABC,1,            1,0));

        step();
        reset = 1'b0;
        chk("rst empty", 64'(infifo_is_empty), 64'd1);
        chk("rst level", 64'(level), 64'd0);
        chk("rst tready", 64'(s_axis_tready), 64'd1);
        chk("rst underflow", 64'(underflow), 64'd0);
        chk("rst overflow", 64'(overflow), 64'd0);

        foreach (vecs[i]) begin
            drive(vecs[i].flush, vecs[i].tvalid, vecs[i].tlast, vecs[i].rd, vecs[i].tdata);
            step();
            chk($sformatf("v%0d empty", i), 64'(infifo_is_empty), 64'(vecs[i].e_empty));
            chk($sformatf("v%0d level", i), 64'(level), 64'(vecs[i].e_level));
            chk($sformatf("v%0d tready", i), 64'(s_axis_tready), 64'(vecs[i].e_tready));
            chk($sformatf("v%0d underflow", i), 64'(underflow), 64'(vecs[i].e_uf));
            chk($sformatf("v%0d overflow", i), 64'(overflow), 64'(vecs[i].e_of));
            if (vecs[i].chk_dout) begin
                chk($sformatf("v%0d dout", i), infifo_dout, vecs[i].e_dout);
                chk($sformatf("v%0d last", i), 64'(infifo_last), 64'(vecs[i].e_last));
            end
        end

        do_reset();
        chk("reset clears underflow", 64'(underflow), 64'd0);
        chk("reset empty", 64'(infifo_is_empty), 64'd1);

        // Fill to 16, hold off a 17th word, simultaneous push+pop while full.
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, (i == 15), 0, 64'(i));
            step();
            chk($sformatf("fill level %0d", i), 64'(level), 64'(i + 1));
        end
        chk("full tready", 64'(s_axis_tready), 64'd0);
        drive(0, 1, 0, 0, 64'd16);
        step();
        chk("held level", 64'(level), 64'd16);
        chk("held head", infifo_dout, 64'd0);
        drive(0, 1, 0, 1, 64'd16);
        step();
        chk("full rw level", 64'(level), 64'd15);
        chk("full rw tready", 64'(s_axis_tready), 64'd1);
        chk("full rw head", infifo_dout, 64'd1);
        drive(0, 1, 0, 0, 64'd16);
        step();
        chk("held accepted level", 64'(level), 64'd16);
        chk("held accepted tready", 64'(s_axis_tready), 64'd0);
        for (int k = 1; k <= 16; k++) begin
            drive(0, 0, 0, 1, '0);
            chk($sformatf("drain dout %0d", k), infifo_dout, 64'(k));
            chk($sformatf("drain last %0d", k), 64'(infifo_last), 64'(k == 15));
            step();
            chk($sformatf("drain tready %0d", k), 64'(s_axis_tready), 64'd1);
        end
        chk("drained empty", 64'(infifo_is_empty), 64'd1);

        // Continuous stream through pointer wrap, one-word occupancy.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            drive(0, 1, (i == 39), (i != 0), 64'h4000_0000_0000_0000 + 64'(i * 3));
            step();
            chk($sformatf("stream level %0d", i), 64'(level), 64'd1);
            chk($sformatf("stream dout %0d", i), infifo_dout, 64'h4000_0000_0000_0000 + 64'(i * 3));
            chk($sformatf("stream last %0d", i), 64'(infifo_last), 64'(i == 39));
        end
        drive(0, 0, 0, 1, '0);
        step();
        chk("stream end empty", 64'(infifo_is_empty), 64'd1);
        chk("stream end level", 64'(level), 64'd0);

        // Overflow stall warning, then reset while the DMA keeps tvalid high.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 0, 0, 64'h5000 + 64'(i));
            step();
        end
        chk("ovf full level", 64'(level), 64'd16);
        for (int c = 1; c <= 16; c++) begin
            drive(0, 1, 0, 0, 64'h6000);
            step();
            chk($sformatf("ovf cycle %0d", c), 64'(overflow), 64'(c == 16));
        end
        drive(0, 1, 0, 0, 64'h6000);
        step();
        chk("ovf sticky", 64'(overflow), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid reset level", 64'(level), 64'd0);
        chk("mid reset tready", 64'(s_axis_tready), 64'd1);
        chk("mid reset overflow", 64'(overflow), 64'd0);
        drive(0, 1, 0, 0, 64'h7777);
        step();
        chk("restart level", 64'(level), 64'd1);
        chk("restart dout", infifo_dout, 64'h7777);

        drive(0, 0, 0, 0, '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
